// File: rtl/ssd1306_spi_tx.sv
// ssd1306_spi_tx: byte serializer for the SSD1306 4-wire SPI port.
// SPI mode 0, MSB first, one full CSn frame per byte. Every phase
// (SETUP, each SCLK half-period, HOLD, GAP) lasts CLK_DIV clk_in cycles.
// All outputs are registered; there is no combinational input-to-output path.
module ssd1306_spi_tx #(
  parameter int CLK_DIV = 4  // clk_in cycles per SCLK half-period, 1..255
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       dc_in,
  output logic       ready,
  output logic       oled_sclk,
  output logic       oled_sdin,
  output logic       oled_csn,
  output logic       oled_dc
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

  state_t     state, state_nxt;
  logic [7:0] div_cnt, div_nxt;
  logic [2:0] bit_cnt, bit_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic       ready_nxt, sclk_nxt, sdin_nxt, csn_nxt, dc_nxt;
  logic       phase_done;

  // The current phase ends on the cycle the divider reaches zero.
  assign phase_done = (div_cnt == 8'd0);

  // State, divider and registered outputs; reset aborts any transfer.
  always_ff @(posedge clk_in) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed by the combinational block.
    if (reset) begin
      state     <= IDLE;
      div_cnt   <= DIV_RELOAD;
      bit_cnt   <= 3'd0;
      shreg     <= 8'd0;
      ready     <= 1'b0;
      oled_sclk <= 1'b0;
      oled_sdin <= 1'b0;
      oled_csn  <= 1'b1;
      oled_dc   <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_nxt;
      bit_cnt   <= bit_nxt;
      shreg     <= shreg_nxt;
      ready     <= ready_nxt;
      oled_sclk <= sclk_nxt;
      oled_sdin <= sdin_nxt;
      oled_csn  <= csn_nxt;
      oled_dc   <= dc_nxt;
    end
  end

  // Next-state and next-output logic for the frame sequence.
  always_comb begin
    // NOTE: every variable gets a default first (hold its value), so no
    // path through the case statement can infer a latch.
    state_nxt = state;
    div_nxt   = phase_done ? DIV_RELOAD : div_cnt - 8'd1;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    ready_nxt = ready;
    sclk_nxt  = oled_sclk;
    sdin_nxt  = oled_sdin;
    csn_nxt   = oled_csn;
    dc_nxt    = oled_dc;

    unique case (state)
      IDLE: begin
        ready_nxt = 1'b1;
        csn_nxt   = 1'b1;
        sclk_nxt  = 1'b0;
        div_nxt   = DIV_RELOAD;
        if (start && ready) begin
          shreg_nxt = data_in;
          dc_nxt    = dc_in;
          sdin_nxt  = data_in[7];
          csn_nxt   = 1'b0;
          ready_nxt = 1'b0;
          bit_nxt   = 3'd0;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (phase_done) begin
          sclk_nxt  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (phase_done) begin
          if (oled_sclk) begin
            // Falling edge: present the next lower bit; the last bit is held.
            sclk_nxt = 1'b0;
            if (bit_cnt != 3'd7) begin
              sdin_nxt  = shreg[6];
              shreg_nxt = {shreg[6:0], 1'b0};
            end
          end else if (bit_cnt == 3'd7) begin
            // Low half of the 8th bit is over.
            bit_nxt   = 3'd0;
            state_nxt = HOLD;
          end else begin
            bit_nxt  = bit_cnt + 3'd1;
            sclk_nxt = 1'b1;
          end
        end
      end
      HOLD: begin
        if (phase_done) begin
          csn_nxt   = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (phase_done) begin
          ready_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ssd1306_spi_tx.sv
// tb_ssd1306_spi_tx: self-checking bench for ssd1306_spi_tx.
// Two instances share clk_in: index 0 with CLK_DIV=2, index 1 with CLK_DIV=1.
// A per-instance monitor decodes SPI frames from the pins and flags protocol
// violations; scenario tasks compare the decoded frames against the bytes
// they sent and the timing rules of the serializer.
module tb_ssd1306_spi_tx;

  typedef struct {
    int         dut;
    logic [7:0] data;
    logic       dc;
    int         rises;
    int         fall_cyc;
    int         rise_cyc;
    int         min_per;
    int         max_per;
  } frame_t;

  logic       clk_in = 1'b0;
  logic       rst     [2];
  logic       start   [2];
  logic [7:0] din     [2];
  logic       dci     [2];
  logic       ready_o [2];
  logic       sclk_o  [2];
  logic       sdin_o  [2];
  logic       csn_o   [2];
  logic       dc_o    [2];

  int     cyc = 0;
  int     vectors = 0;
  int     miscompares = 0;
  frame_t frames[$];

  always #5 clk_in = ~clk_in;

  // Cycle counter: value seen after a posedge is the index of that edge.
  always @(posedge clk_in) cyc <= cyc + 1;

  ssd1306_spi_tx #(.CLK_DIV(2)) u_div2 (
    .clk_in   (clk_in),
    .reset    (rst[0]),
    .start    (start[0]),
    .data_in  (din[0]),
    .dc_in    (dci[0]),
    .ready    (ready_o[0]),
    .oled_sclk(sclk_o[0]),
    .oled_sdin(sdin_o[0]),
    .oled_csn (csn_o[0]),
    .oled_dc  (dc_o[0])
  );

  ssd1306_spi_tx #(.CLK_DIV(1)) u_div1 (
    .clk_in   (clk_in),
    .reset    (rst[1]),
    .start    (start[1]),
    .data_in  (din[1]),
    .dc_in    (dci[1]),
    .ready    (ready_o[1]),
    .oled_sclk(sclk_o[1]),
    .oled_sdin(sdin_o[1]),
    .oled_csn (csn_o[1]),
    .oled_dc  (dc_o[1])
  );

  // Pin-level monitors: sample on the falling clk_in edge, decode frames.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic       prev_sclk = 1'b0;
    logic       prev_csn  = 1'b1;
    logic       prev_dc   = 1'b0;
    logic       in_frame  = 1'b0;
    logic [7:0] rx = 8'd0;
    int         rises = 0;
    int         last_rise = -1;
    int         min_per = 0;
    int         max_per = 0;
    int         fall_cyc = 0;
    frame_t     fr;

    initial forever begin
      @(negedge clk_in);
      if (rst[g] === 1'b1) begin
        in_frame = 1'b0;
      end else begin
        if (sclk_o[g] !== prev_sclk) begin
          vectors++;
          if (csn_o[g] !== 1'b0 || prev_csn !== 1'b0) begin
            miscompares++;
            $display("FAIL sclk_edge_csn_high dut%0d cyc %0d: csn=%b/%b during sclk edge, required 0",
                     g, cyc, prev_csn, csn_o[g]);
          end
        end
        if (dc_o[g] !== prev_dc) begin
          vectors++;
          if (prev_csn !== 1'b1) begin
            miscompares++;
            $display("FAIL dc_change_csn_low dut%0d cyc %0d: dc %b->%b while csn=%b, required csn=1",
                     g, cyc, prev_dc, dc_o[g], prev_csn);
          end
        end
        if (prev_csn === 1'b1 && csn_o[g] === 1'b0) begin
          in_frame  = 1'b1;
          rises     = 0;
          rx        = 8'd0;
          last_rise = -1;
          min_per   = 1000000;
          max_per   = 0;
          fall_cyc  = cyc;
        end
        if (in_frame && prev_sclk === 1'b0 && sclk_o[g] === 1'b1) begin
          rx = {rx[6:0], sdin_o[g]};
          if (last_rise >= 0) begin
            if (cyc - last_rise < min_per) min_per = cyc - last_rise;
            if (cyc - last_rise > max_per) max_per = cyc - last_rise;
          end
          last_rise = cyc;
          rises++;
        end
        if (in_frame && prev_csn === 1'b0 && csn_o[g] === 1'b1) begin
          fr.dut      = g;
          fr.data     = rx;
          fr.dc       = dc_o[g];
          fr.rises    = rises;
          fr.fall_cyc = fall_cyc;
          fr.rise_cyc = cyc;
          fr.min_per  = min_per;
          fr.max_per  = max_per;
          frames.push_back(fr);
          in_frame = 1'b0;
        end
      end
      prev_sclk = sclk_o[g];
      prev_csn  = csn_o[g];
      prev_dc   = dc_o[g];
    end
  end

  function automatic int div_of(input int g);
    return (g == 0) ? 2 : 1;
  endfunction

  // Advance to just after the next falling edge; inputs change only here.
  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  // Present a byte with start=1 for one edge; acc is the accept edge index.
  task automatic send(input int g, input logic [7:0] d, input logic dcv, output int acc);
    start[g] = 1'b1;
    din[g]   = d;
    dci[g]   = dcv;
    tick();
    start[g] = 1'b0;
    acc      = cyc;
    din[g]   = 8'($urandom);
    dci[g]   = 1'($urandom);
  endtask

  // Wait (bounded) for ready=1; lat is edges since acc.
  task automatic wait_ready(input int g, input int acc, output int lat, output bit timed_out);
    int n;
    n = 0;
    while (ready_o[g] !== 1'b1 && n < 19 * div_of(g) + 40) begin
      tick();
      n++;
    end
    timed_out = (ready_o[g] !== 1'b1);
    lat = cyc - acc;
  endtask

  task automatic get_frame(output frame_t f, output bit ok);
    ok = (frames.size() > 0);
    if (ok) f = frames.pop_front();
    else    f = '{default: 0};
  endtask

  task automatic test_reset();
    rst[0] = 1'b1; rst[1] = 1'b1;
    for (int g = 0; g < 2; g++) begin
      start[g] = 1'b0; din[g] = 8'd0; dci[g] = 1'b0;
    end
    tick();
    tick();
    for (int g = 0; g < 2; g++) begin
      vectors++;
      if ({ready_o[g], sclk_o[g], sdin_o[g], csn_o[g], dc_o[g]} !== 5'b00010) begin
        miscompares++;
        $display("FAIL reset_outputs dut%0d: {ready,sclk,sdin,csn,dc}=%b, required 00010",
                 g, {ready_o[g], sclk_o[g], sdin_o[g], csn_o[g], dc_o[g]});
      end
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    tick();
    for (int g = 0; g < 2; g++) begin
      vectors++;
      if (ready_o[g] !== 1'b1) begin
        miscompares++;
        $display("FAIL ready_after_reset dut%0d: ready=%b, required 1", g, ready_o[g]);
      end
    end
  endtask

  // Single byte 0xAE, command, at CLK_DIV=2.
  task automatic test_single_byte();
    int acc, lat;
    bit to, ok;
    frame_t f;
    frames.delete();
    send(0, 8'hAE, 1'b0, acc);
    vectors++;
    if ({csn_o[0], ready_o[0], sdin_o[0], dc_o[0]} !== 4'b0010) begin
      miscompares++;
      $display("FAIL accept_edge: {csn,ready,sdin,dc}=%b, required 0010",
               {csn_o[0], ready_o[0], sdin_o[0], dc_o[0]});
    end
    wait_ready(0, acc, lat, to);
    vectors++;
    if (to || lat != 38) begin
      miscompares++;
      $display("FAIL latency_div2: %0d cycles (timeout=%0d), required 38", lat, to);
    end
    get_frame(f, ok);
    vectors++;
    if (!ok || f.data !== 8'hAE || f.dc !== 1'b0 || f.rises != 8) begin
      miscompares++;
      $display("FAIL frame_ae: present=%0d data=%h dc=%b rises=%0d, required data=ae dc=0 rises=8",
               ok, f.data, f.dc, f.rises);
    end
    vectors++;
    if (f.min_per != 4 || f.max_per != 4) begin
      miscompares++;
      $display("FAIL sclk_period_div2: min=%0d max=%0d, required 4", f.min_per, f.max_per);
    end
  endtask

  // start held high across two bytes; second accepted on first ready cycle.
  task automatic test_back_to_back(input int g);
    int acc1, acc2, lat, d;
    bit to, ok1, ok2;
    frame_t f1, f2;
    d = div_of(g);
    frames.delete();
    start[g] = 1'b1; din[g] = 8'hA5; dci[g] = 1'b1;
    tick();
    acc1 = cyc;
    din[g] = 8'h3C; dci[g] = 1'b0;
    wait_ready(g, acc1, lat, to);
    vectors++;
    if (to || lat != 19 * d) begin
      miscompares++;
      $display("FAIL b2b_latency1 dut%0d: %0d cycles (timeout=%0d), required %0d", g, lat, to, 19 * d);
    end
    tick();
    acc2 = cyc;
    start[g] = 1'b0;
    vectors++;
    if ({ready_o[g], csn_o[g], dc_o[g]} !== 3'b000) begin
      miscompares++;
      $display("FAIL b2b_second_accept dut%0d: {ready,csn,dc}=%b, required 000",
               g, {ready_o[g], csn_o[g], dc_o[g]});
    end
    wait_ready(g, acc2, lat, to);
    get_frame(f1, ok1);
    get_frame(f2, ok2);
    vectors++;
    if (!ok1 || f1.data !== 8'hA5 || f1.dc !== 1'b1 || f1.rises != 8) begin
      miscompares++;
      $display("FAIL b2b_frame1 dut%0d: present=%0d data=%h dc=%b rises=%0d, required a5/1/8",
               g, ok1, f1.data, f1.dc, f1.rises);
    end
    vectors++;
    if (!ok2 || f2.data !== 8'h3C || f2.dc !== 1'b0 || f2.rises != 8) begin
      miscompares++;
      $display("FAIL b2b_frame2 dut%0d: present=%0d data=%h dc=%b rises=%0d, required 3c/0/8",
               g, ok2, f2.data, f2.dc, f2.rises);
    end
    vectors++;
    if (f2.fall_cyc - f1.rise_cyc != d + 1) begin
      miscompares++;
      $display("FAIL b2b_csn_gap dut%0d: csn high %0d cycles, required %0d",
               g, f2.fall_cyc - f1.rise_cyc, d + 1);
    end
  endtask

  // start pulses while busy must be ignored, not queued.
  task automatic test_ignore_busy();
    int acc, lat;
    bit to, ok;
    frame_t f;
    frames.delete();
    send(0, 8'h5A, 1'b1, acc);
    for (int i = 0; i < 12; i++) begin
      start[0] = (i == 5 || i == 9);
      din[0]   = 8'h10 + 8'(i);
      dci[0]   = 1'b0;
      tick();
    end
    start[0] = 1'b0;
    wait_ready(0, acc, lat, to);
    repeat (40) tick();
    get_frame(f, ok);
    vectors++;
    if (!ok || f.data !== 8'h5A || f.dc !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_frame: present=%0d data=%h dc=%b, required 5a/1", ok, f.data, f.dc);
    end
    vectors++;
    if (frames.size() != 0 || ready_o[0] !== 1'b1 || dc_o[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_no_extra: extra frames=%0d ready=%b dc=%b, required 0/1/1",
               frames.size(), ready_o[0], dc_o[0]);
    end
  endtask

  // One-cycle reset in the high half of bit 4 of 0xFF, then 0x81.
  task automatic test_reset_abort();
    int acc, lat, n;
    bit to, ok;
    frame_t f;
    frames.delete();
    send(0, 8'hFF, 1'b1, acc);
    n = 0;
    while (cyc - acc < 19 && n < 40) begin
      tick();
      n++;
    end
    vectors++;
    if (sclk_o[0] !== 1'b1 || csn_o[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_midbit: sclk=%b csn=%b, required 1/0", sclk_o[0], csn_o[0]);
    end
    rst[0] = 1'b1;
    tick();
    vectors++;
    if ({csn_o[0], sclk_o[0], ready_o[0]} !== 3'b100) begin
      miscompares++;
      $display("FAIL abort_reset_edge: {csn,sclk,ready}=%b, required 100",
               {csn_o[0], sclk_o[0], ready_o[0]});
    end
    rst[0] = 1'b0;
    tick();
    vectors++;
    if (ready_o[0] !== 1'b1 || frames.size() != 0) begin
      miscompares++;
      $display("FAIL abort_recover: ready=%b frames=%0d, required 1/0", ready_o[0], frames.size());
    end
    send(0, 8'h81, 1'b0, acc);
    wait_ready(0, acc, lat, to);
    get_frame(f, ok);
    vectors++;
    if (to || lat != 38 || !ok || f.data !== 8'h81 || f.dc !== 1'b0 || f.rises != 8) begin
      miscompares++;
      $display("FAIL abort_next_byte: lat=%0d present=%0d data=%h dc=%b rises=%0d, required 38/1/81/0/8",
               lat, ok, f.data, f.dc, f.rises);
    end
  endtask

  // CLK_DIV=1: 0x00 then 0xFF, 19 cycles each, SCLK period 2.
  task automatic test_clkdiv1();
    logic [7:0] bytes [2];
    int acc, lat;
    bit to, ok;
    frame_t f;
    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    frames.delete();
    for (int i = 0; i < 2; i++) begin
      send(1, bytes[i], 1'(i), acc);
      wait_ready(1, acc, lat, to);
      get_frame(f, ok);
      vectors++;
      if (to || lat != 19) begin
        miscompares++;
        $display("FAIL div1_latency byte%0d: %0d cycles (timeout=%0d), required 19", i, lat, to);
      end
      vectors++;
      if (!ok || f.data !== bytes[i] || f.dc !== 1'(i) || f.rises != 8 ||
          f.min_per != 2 || f.max_per != 2) begin
        miscompares++;
        $display("FAIL div1_frame byte%0d: data=%h dc=%b rises=%0d per=%0d..%0d, required %h/%0d/8/2",
                 i, f.data, f.dc, f.rises, f.min_per, f.max_per, bytes[i], i);
      end
    end
  endtask

  // Random bytes on both instances against the byte/flag reference queue.
  task automatic test_random();
    logic [8:0] expected[$];
    logic [8:0] e;
    int acc, lat, g;
    bit to, ok;
    frame_t f;
    frames.delete();
    for (int i = 0; i < 12; i++) begin
      g = i % 2;
      e = 9'($urandom);
      expected.push_back(e);
      repeat ($urandom_range(0, 3)) tick();
      send(g, e[7:0], e[8], acc);
      wait_ready(g, acc, lat, to);
      get_frame(f, ok);
      e = expected.pop_front();
      vectors++;
      if (to || lat != 19 * div_of(g) || !ok || f.dut != g || {f.dc, f.data} !== e || f.rises != 8) begin
        miscompares++;
        $display("FAIL random_%0d dut%0d: lat=%0d dc/data=%b/%h rises=%0d, required lat=%0d dc/data=%b/%h rises=8",
                 i, g, lat, f.dc, f.data, f.rises, 19 * div_of(g), e[8], e[7:0]);
      end
    end
  endtask

  initial begin
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    test_reset();
    test_single_byte();
    test_back_to_back(1);
    test_back_to_back(0);
    test_ignore_busy();
    test_reset_abort();
    test_clkdiv1();
    test_random();
    repeat (10) tick();
    vectors++;
    if (frames.size() != 0) begin
      miscompares++;
      $display("FAIL stray_frames: %0d unexpected frames, required 0", frames.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
